rw_cmd_responder: RTL and testbench

Server-side executor for the read/write command stream issued by emulation clients over multisim. It accepts 192-bit commands `{wdata, address, op}` on a valid/ready push interface, executes them against an internal 64-bit word memory, and returns one 64-bit response per command on a valid/ready pull interface. It also acknowledges the client's exit request once no command is in flight, and keeps access and error statistics. It sits in the emulated design behind the `rw_cmd`, `rw_rsp` and `exit` multisim server instances.

---
 rtl/rw_cmd_pkg.sv | 26 ++
 rtl/rw_cmd_mem.sv | 29 ++
 rtl/rw_cmd_responder.sv | 146 ++++++++++++++
 tb/tb_rw_cmd_responder.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_cmd_pkg.sv
// Shared types for the read/write command responder.
// Command layout, opcodes, FSM states and the bad-op response word.
package rw_cmd_pkg;

    typedef enum logic [63:0] {
        RW_OP_WRITE = 64'd0,
        RW_OP_READ  = 64'd1
    } rw_op_e;

    // Field order matches the flat 192-bit command bus:
    // [191:128] wdata, [127:64] address, [63:0] op.
    typedef struct packed {
        logic [63:0] wdata;
        logic [63:0] address;
        logic [63:0] op;
    } rw_cmd_t;

    localparam logic [63:0] RW_RSP_BAD_OP = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } rw_state_e;

endpackage

// File: rtl/rw_cmd_mem.sv
// Single-port 64-bit synchronous RAM, one-cycle read latency.
// Ports: clk, i_we/i_re, i_addr, i_wdata in; o_rdata out (holds when idle).
module rw_cmd_mem #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [63:0]              i_wdata,
    output logic [63:0]              o_rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // No reset on the array or read register so tools map this to RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rw_cmd_responder.sv
// Executes read/write commands against a word memory, one at a time.
// Ports: cmd push (cmd_vld/rdy/cmd), rsp pull (rsp_vld/rdy/rsp),
// exit handshake (exit_vld/rdy, done), saturating wr/rd/err counters.
module rw_cmd_responder
    import rw_cmd_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [191:0]         cmd,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [63:0]          rsp,
    input  logic                 exit_vld,
    output logic                 exit_rdy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int AW = $clog2(DEPTH);

    rw_state_e            r_state;
    rw_cmd_t              r_cmd;
    logic [63:0]          r_rsp;
    logic                 r_rsp_mem;
    logic                 r_exit_rdy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_wr_count;
    logic [CNT_WIDTH-1:0] r_rd_count;
    logic [CNT_WIDTH-1:0] r_err_count;

    logic        w_cmd_hs;
    logic        w_exit_ack;
    logic        w_in_range;
    logic        w_is_wr;
    logic        w_is_rd;
    logic        w_do_wr;
    logic        w_do_rd;
    logic        w_err;
    logic [63:0] w_rsp_nxt;
    logic        w_exec;
    logic [63:0] w_mem_rdata;

    assign cmd_rdy  = (r_state == ST_IDLE) && !r_done;
    assign w_cmd_hs = cmd_vld && cmd_rdy;
    assign w_exec   = (r_state == ST_EXEC);

    // r_exit_rdy guard stops a second ack while done is still rising.
    assign w_exit_ack = (r_state == ST_IDLE) && exit_vld && !r_done
                        && !w_cmd_hs && !r_exit_rdy;

    // Full 64-bit compare: high address bits must never alias.
    assign w_in_range = r_cmd.address < 64'(DEPTH);
    assign w_is_wr    = r_cmd.op == RW_OP_WRITE;
    assign w_is_rd    = r_cmd.op == RW_OP_READ;

    always_comb begin
        w_do_wr   = 1'b0;
        w_do_rd   = 1'b0;
        w_err     = 1'b0;
        w_rsp_nxt = '0;
        unique case (1'b1)
            w_is_wr && w_in_range: w_do_wr = 1'b1;
            w_is_rd && w_in_range: w_do_rd = 1'b1;
            (w_is_wr || w_is_rd) && !w_in_range: w_err = 1'b1;
            default: begin
                w_err     = 1'b1;
                w_rsp_nxt = RW_RSP_BAD_OP;
            end
        endcase
    end

    rw_cmd_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_exec && w_do_wr),
        .i_re    (w_exec && w_do_rd),
        .i_addr  (r_cmd.address[AW-1:0]),
        .i_wdata (r_cmd.wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_rsp       <= '0;
            r_rsp_mem   <= 1'b0;
            r_exit_rdy  <= 1'b0;
            r_done      <= 1'b0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_err_count <= '0;
        end else begin
            r_exit_rdy <= w_exit_ack;
            if (r_exit_rdy) begin
                r_done <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cmd   <= rw_cmd_t'(cmd);
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp     <= w_rsp_nxt;
                    r_rsp_mem <= w_do_rd;
                    if (w_do_wr && r_wr_count != '1) begin
                        r_wr_count <= r_wr_count + 1'b1;
                    end
                    if (w_do_rd && r_rd_count != '1) begin
                        r_rd_count <= r_rd_count + 1'b1;
                    end
                    if (w_err && r_err_count != '1) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data stays in the RAM output register through RESP.
    assign rsp       = r_rsp_mem ? w_mem_rdata : r_rsp;
    assign rsp_vld   = (r_state == ST_RESP);
    assign exit_rdy  = r_exit_rdy;
    assign done      = r_done;
    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_rw_cmd_responder.sv
// Directed bench for rw_cmd_responder.
// Main instance DEPTH=1024/CNT_WIDTH=32, second instance CNT_WIDTH=4.
module tb_rw_cmd_responder;

    localparam logic [63:0] BASE = 64'hBEBE_CACA_DEAD_B00B;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [191:0] cmd;
    logic         rsp_vld;
    logic         rsp_rdy;
    logic [63:0]  rsp;
    logic         exit_vld;
    logic         exit_rdy;
    logic         done;
    logic [31:0]  wr_count;
    logic [31:0]  rd_count;
    logic [31:0]  err_count;

    logic         s_cmd_vld;
    logic         s_cmd_rdy;
    logic [191:0] s_cmd;
    logic         s_rsp_vld;
    logic         s_rsp_rdy;
    logic [63:0]  s_rsp;
    logic         s_exit_vld;
    logic         s_exit_rdy;
    logic         s_done;
    logic [3:0]   s_wr_count;
    logic [3:0]   s_rd_count;
    logic [3:0]   s_err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rw_cmd_responder #(.DEPTH(1024), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp(rsp),
        .exit_vld(exit_vld), .exit_rdy(exit_rdy), .done(done),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    rw_cmd_responder #(.DEPTH(16), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(s_cmd_vld), .cmd_rdy(s_cmd_rdy), .cmd(s_cmd),
        .rsp_vld(s_rsp_vld), .rsp_rdy(s_rsp_rdy), .rsp(s_rsp),
        .exit_vld(s_exit_vld), .exit_rdy(s_exit_rdy), .done(s_done),
        .wr_count(s_wr_count), .rd_count(s_rd_count), .err_count(s_err_count)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    // Drives one command and collects its response; bounded waits.
    task automatic run_cmd(input logic [63:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, output logic [63:0] r);
        int n;
        r = 'x;
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd     = {wdata, addr, op};
        n = 0;
        while (!cmd_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_rdy) begin
            errors++;
            $display("FAIL cmd_accept: cmd_rdy=%b required 1", cmd_rdy);
            cmd_vld = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        n = 0;
        while (!rsp_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp_vld) begin
            errors++;
            $display("FAIL rsp_wait: rsp_vld=%b required 1", rsp_vld);
            return;
        end
        r = rsp;
        rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_rdy, rsp_vld, exit_rdy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 1000",
                     {cmd_rdy, rsp_vld, exit_rdy, done});
        end
        checks++;
        if (rsp !== 64'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %h required 0", rsp);
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d %0d %0d required 0 0 0",
                     wr_count, rd_count, err_count);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] r;
        for (int i = 0; i < 10; i++) begin
            run_cmd(64'd0, 64'(i), BASE + 64'(i), r);
            checks++;
            if (r !== 64'd0) begin
                errors++;
                $display("FAIL wr_rsp[%0d]: got %h required 0", i, r);
            end
        end
        for (int i = 0; i < 10; i++) begin
            run_cmd(64'd1, 64'(i), 64'd0, r);
            checks++;
            if (r !== BASE + 64'(i)) begin
                errors++;
                $display("FAIL rd_rsp[%0d]: got %h required %h", i, r, BASE + 64'(i));
            end
        end
        checks++;
        if (wr_count !== 32'd10 || rd_count !== 32'd10 || err_count !== 32'd0) begin
            errors++;
            $display("FAIL wr_rd_counts: got %0d %0d %0d required 10 10 0",
                     wr_count, rd_count, err_count);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] r;
        int bad;
        run_cmd(64'd0, 64'd3, 64'h1234, r);
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd     = {64'd0, 64'd3, 64'd1};
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        checks++;
        if (rsp_vld !== 1'b0 || cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_exec: rsp_vld=%b cmd_rdy=%b required 0 0", rsp_vld, cmd_rdy);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_vld !== 1'b1 || rsp !== 64'h1234 || cmd_rdy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (rsp=%h)", bad, rsp);
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_rdy = 1'b0;
        checks++;
        if (rsp_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rsp_vld=%b cmd_rdy=%b required 0 1", rsp_vld, cmd_rdy);
        end
    endtask

    task automatic test_errors();
        logic [63:0] r;
        run_cmd(64'd7, 64'd0, 64'd0, r);
        checks++;
        if (r !== '1) begin
            errors++;
            $display("FAIL err_badop: got %h required all-ones", r);
        end
        run_cmd(64'd0, 64'd1024, 64'h0BAD_0BAD_0BAD_0BAD, r);
        checks++;
        if (r !== 64'd0) begin
            errors++;
            $display("FAIL err_wr_range: got %h required 0", r);
        end
        run_cmd(64'd1, 64'h1_0000_0000, 64'd0, r);
        checks++;
        if (r !== 64'd0) begin
            errors++;
            $display("FAIL err_rd_range: got %h required 0", r);
        end
        checks++;
        if (err_count !== 32'd3) begin
            errors++;
            $display("FAIL err_count: got %0d required 3", err_count);
        end
        run_cmd(64'd1, 64'd0, 64'd0, r);
        checks++;
        if (r !== BASE) begin
            errors++;
            $display("FAIL err_mem0: got %h required %h", r, BASE);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        run_cmd(64'd0, 64'd5, 64'h55AA, r);
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd     = {64'd0, 64'd5, 64'd1};
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_vld !== 1'b1) begin
            errors++;
            $display("FAIL rm_resp: rsp_vld=%b required 1", rsp_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || wr_count !== 32'd0 || err_count !== 32'd0) begin
            errors++;
            $display("FAIL rm_async: rsp_vld=%b wr=%0d err=%0d required 0 0 0",
                     rsp_vld, wr_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL rm_release: cmd_rdy=%b rsp_vld=%b required 1 0", cmd_rdy, rsp_vld);
        end
        run_cmd(64'd1, 64'd5, 64'd0, r);
        checks++;
        if (r !== 64'h55AA) begin
            errors++;
            $display("FAIL rm_persist5: got %h required 55aa", r);
        end
        run_cmd(64'd1, 64'd3, 64'd0, r);
        checks++;
        if (r !== 64'h1234) begin
            errors++;
            $display("FAIL rm_persist3: got %h required 1234", r);
        end
        checks++;
        if (rd_count !== 32'd2) begin
            errors++;
            $display("FAIL rm_rd_count: got %0d required 2", rd_count);
        end
    endtask

    task automatic test_exit();
        int early;
        int pulses;
        int n;
        int bad;
        @(negedge clk);
        cmd_vld  = 1'b1;
        exit_vld = 1'b1;
        cmd      = {64'd0, 64'd1, 64'd1};
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        early = 0;
        n = 0;
        while (!rsp_vld && n < 20) begin
            if (exit_rdy) early++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp !== BASE + 64'd1 || rsp_vld !== 1'b1) begin
            errors++;
            $display("FAIL exit_rd: rsp=%h vld=%b required %h 1", rsp, rsp_vld, BASE + 64'd1);
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_rdy = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (exit_rdy) begin
                pulses++;
                exit_vld = 1'b0;
            end
            @(negedge clk);
        end
        exit_vld = 1'b0;
        checks++;
        if (early != 0 || pulses != 1) begin
            errors++;
            $display("FAIL exit_pulse: early=%0d pulses=%0d required 0 1", early, pulses);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL exit_done: got %b required 1", done);
        end
        cmd_vld  = 1'b1;
        exit_vld = 1'b1;
        cmd      = {64'd0, 64'd2, 64'd1};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cmd_rdy !== 1'b0 || exit_rdy !== 1'b0 || rsp_vld !== 1'b0) bad++;
        end
        cmd_vld  = 1'b0;
        exit_vld = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL exit_locked: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_throughput();
        int n;
        int last;
        int gaps;
        logic [63:0] r;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b1;
        cmd_vld = 1'b1;
        n = 0;
        last = -1;
        gaps = 0;
        for (int i = 0; i < 700 && n < 200; i++) begin
            @(negedge clk);
            cmd = {64'(n) * 64'd3, 64'(n), 64'd0};
            if (cmd_rdy) begin
                if (last >= 0 && i - last != 3) gaps++;
                last = i;
                n++;
            end
        end
        @(posedge clk);
        #1 cmd_vld = 1'b0;
        repeat (5) @(negedge clk);
        rsp_rdy = 1'b0;
        checks++;
        if (n != 200 || gaps != 0) begin
            errors++;
            $display("FAIL tput: accepted=%0d gaps=%0d required 200 0", n, gaps);
        end
        checks++;
        if (wr_count !== 32'd200) begin
            errors++;
            $display("FAIL tput_count: got %0d required 200", wr_count);
        end
        run_cmd(64'd1, 64'd199, 64'd0, r);
        checks++;
        if (r !== 64'd597) begin
            errors++;
            $display("FAIL tput_data: got %0d required 597", r);
        end
    endtask

    task automatic test_saturation();
        int n;
        s_rsp_rdy = 1'b1;
        s_cmd_vld = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            @(negedge clk);
            s_cmd = {64'(n), 64'(n % 16), 64'd0};
            if (s_cmd_rdy) n++;
        end
        @(posedge clk);
        #1 s_cmd_vld = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (n != 20 || s_wr_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_wr: accepted=%0d wr_count=%0d required 20 15", n, s_wr_count);
        end
        checks++;
        if (s_err_count !== 4'd0 || s_rd_count !== 4'd0) begin
            errors++;
            $display("FAIL sat_other: err=%0d rd=%0d required 0 0", s_err_count, s_rd_count);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_vld    = 1'b0;
        cmd        = '0;
        rsp_rdy    = 1'b0;
        exit_vld   = 1'b0;
        s_cmd_vld  = 1'b0;
        s_cmd      = '0;
        s_rsp_rdy  = 1'b0;
        s_exit_vld = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_exit();
        test_throughput();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
